// File: rtl/cache_controller_pkg.sv
// Shared types and address-field helpers for the two-way data cache.
package cache_controller_pkg;

  localparam int INDEX_W   = 6;
  localparam int TAG_W     = 10;
  localparam int DATA_W    = 32;
  localparam int LINE_W    = 2 * DATA_W;
  localparam int SETS      = 1 << INDEX_W;
  localparam int WORD_BIT  = 2;
  localparam int INDEX_LSB = 3;
  localparam int TAG_LSB   = INDEX_LSB + INDEX_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ_MISS = 2'd1,
    WRITE     = 2'd2
  } state_t;

  function automatic logic [INDEX_W-1:0] addr_index(input logic [31:0] a);
    return a[TAG_LSB-1:INDEX_LSB];
  endfunction

  function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] a);
    return a[TAG_LSB+TAG_W-1:TAG_LSB];
  endfunction

endpackage

// File: rtl/cache_controller_mem.sv
// Two-way tag/valid/data arrays with per-set LRU; combinational lookup,
// synchronous line fill and single-word update at the looked-up index.
module cache_mem
  import cache_controller_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] index,
  input  logic [TAG_W-1:0]   tag,
  output logic [1:0]         hit,
  output logic [LINE_W-1:0]  hit_line,
  output logic               victim,
  input  logic               fill_en,
  input  logic               fill_way,
  input  logic [LINE_W-1:0]  fill_line,
  input  logic               upd_en,
  input  logic               upd_way,
  input  logic               upd_word,
  input  logic [DATA_W-1:0]  upd_val,
  input  logic               touch_en,
  input  logic               touch_way
);

  logic [SETS-1:0]   valid [2];
  logic [SETS-1:0]   lru;
  logic [TAG_W-1:0]  tags  [2][SETS];
  logic [LINE_W-1:0] data  [2][SETS];

  always_comb begin
    hit[0]   = valid[0][index] && (tags[0][index] == tag);
    hit[1]   = valid[1][index] && (tags[1][index] == tag);
    hit_line = hit[1] ? data[1][index] : data[0][index];
    if (!valid[0][index])      victim = 1'b0;
    else if (!valid[1][index]) victim = 1'b1;
    else                       victim = lru[index];
  end

  // LRU always names the way that was not just used
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid[0] <= '0;
      valid[1] <= '0;
      lru      <= '0;
    end else if (fill_en) begin
      valid[fill_way][index] <= 1'b1;
      lru[index]             <= ~fill_way;
    end else if (touch_en) begin
      lru[index] <= ~touch_way;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      tags[fill_way][index] <= tag;
      data[fill_way][index] <= fill_line;
    end else if (upd_en) begin
      if (upd_word) data[upd_way][index][LINE_W-1:DATA_W] <= upd_val;
      else          data[upd_way][index][DATA_W-1:0]      <= upd_val;
    end
  end

endmodule

// File: rtl/cache_controller.sv
// Write-through, no-write-allocate 2-way data cache: FSM and SRAM handshake.
// state     | meaning
// IDLE      | accepting requests; read hits served with zero stall
// READ_MISS | line fetch outstanding; fill and bypass on sram_ready
// WRITE     | store forwarded to SRAM; cached word updated on a hit
module cache_controller
  import cache_controller_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              read_en,
  input  logic              write_en,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] st_val,
  output logic [DATA_W-1:0] read_data,
  output logic              ready,
  output logic              sram_read_en,
  output logic              sram_write_en,
  output logic [31:0]       sram_addr,
  output logic [DATA_W-1:0] sram_st_val,
  input  logic [LINE_W-1:0] sram_read_data,
  input  logic              sram_ready
);

  state_t            state;
  logic [31:0]       addr_q;
  logic [DATA_W-1:0] st_q;
  logic [31:0]       lk_addr;
  logic [1:0]        lk_hit;
  logic [LINE_W-1:0] lk_line;
  logic              victim;
  logic              hit;
  logic              hit_way;
  logic [DATA_W-1:0] hit_word;
  logic [DATA_W-1:0] fill_word;
  logic              fill_en;
  logic              upd_en;
  logic              touch_en;
  logic              unused_addr_bits;

  // Wait states look up the latched address so fill/update hit the right set
  assign lk_addr          = (state == IDLE) ? addr : addr_q;
  assign unused_addr_bits = ^{lk_addr[31:TAG_LSB+TAG_W], lk_addr[1:0]};
  assign hit              = |lk_hit;
  assign hit_way          = lk_hit[1];
  assign hit_word  = lk_addr[WORD_BIT] ? lk_line[LINE_W-1:DATA_W] : lk_line[DATA_W-1:0];
  assign fill_word = addr_q[WORD_BIT] ? sram_read_data[LINE_W-1:DATA_W]
                                      : sram_read_data[DATA_W-1:0];

  assign fill_en  = (state == READ_MISS) && sram_ready;
  assign upd_en   = (state == WRITE) && sram_ready && hit;
  assign touch_en = ((state == IDLE) && read_en && hit) || upd_en;

  assign sram_addr   = addr_q;
  assign sram_st_val = st_q;

  cache_mem u_mem (
    .clk       (clk),
    .rst       (rst),
    .index     (addr_index(lk_addr)),
    .tag       (addr_tag(lk_addr)),
    .hit       (lk_hit),
    .hit_line  (lk_line),
    .victim    (victim),
    .fill_en   (fill_en),
    .fill_way  (victim),
    .fill_line (sram_read_data),
    .upd_en    (upd_en),
    .upd_way   (hit_way),
    .upd_word  (addr_q[WORD_BIT]),
    .upd_val   (st_q),
    .touch_en  (touch_en),
    .touch_way (hit_way)
  );

  always_comb begin
    ready     = 1'b1;
    read_data = '0;
    case (state)
      IDLE: begin
        ready = read_en ? hit : !write_en;
        if (hit) read_data = hit_word;
      end
      READ_MISS: begin
        ready = sram_ready;
        if (sram_ready) read_data = fill_word;
      end
      WRITE:   ready = sram_ready;
      default: ready = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      addr_q        <= '0;
      st_q          <= '0;
      sram_read_en  <= 1'b0;
      sram_write_en <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (read_en) begin
            if (!hit) begin
              state        <= READ_MISS;
              addr_q       <= addr;
              sram_read_en <= 1'b1;
            end
          end else if (write_en) begin
            state         <= WRITE;
            addr_q        <= addr;
            st_q          <= st_val;
            sram_write_en <= 1'b1;
          end
        end
        READ_MISS: if (sram_ready) begin
          state        <= IDLE;
          sram_read_en <= 1'b0;
        end
        WRITE: if (sram_ready) begin
          state         <= IDLE;
          sram_write_en <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
